// File: rtl/fixed_to_fp16.sv
// -----------------------------------------------------------------------------
// fixed_to_fp16
//   Streaming encoder from signed two's-complement fixed-point (value =
//   in_data / 2^FRAC_BITS) to IEEE-754 binary16. Rounding is round-to-nearest-
//   even. Magnitudes above the FP16 range saturate to +/-inf. Small values
//   denormalise to subnormals. A zero input, or a result that rounds to zero,
//   is always encoded as +0. NaN is never produced.
//
//   Pipeline (all three stages advance together, bubbles are kept):
//     S1  sign extraction and absolute value
//     S2  leading-zero count, normalisation, unbiased->biased exponent
//     S3  11-bit significand select, guard/sticky, RNE, overflow/subnormal
//         pack into the registered output
//   adv = !out_valid | out_ready, and in_ready = adv.
//   Latency is 3 cycles from accept to out_valid. Throughput is 1 word/cycle.
//
// Parameters
//   IN_W       input width, 8..32
//   FRAC_BITS  input fractional bits, 0..IN_W-1
//
// Ports
//   clk          in   1     rising-edge clock
//   rst_n        in   1     asynchronous active-low reset
//   in_valid     in   1     input word valid
//   in_ready     out  1     input accepted this cycle when in_valid is high
//   in_data      in   IN_W  signed fixed-point input
//   out_valid    out  1     out_data valid
//   out_ready    in   1     downstream accepts output
//   out_data     out  16    FP16 result {sign, exp[4:0], frac[9:0]}
//   out_inexact  out  1     result was rounded or overflowed
//                           (present only with FP16_INEXACT_EN)
//
// Build option
//   FP16_INEXACT_EN  when defined, adds the registered out_inexact flag.
//                    out_data is identical in both builds.
// -----------------------------------------------------------------------------
module fixed_to_fp16 #(
    parameter int IN_W      = 16,
    parameter int FRAC_BITS = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [15:0]     out_data
`ifdef FP16_INEXACT_EN
    ,
    output logic            out_inexact
`endif
);

    // Width of the leading-zero count. It must hold IN_W itself for a zero word.
    localparam int LZW = $clog2(IN_W + 1);
    // The normalised significand is padded with zeros so that a subnormal
    // right shift never pushes set bits off the bottom. All shifted-out
    // information then stays visible to the sticky OR.
    localparam int PAD = 32;
    localparam int WW  = IN_W + PAD;
    // Biased exponent of a word whose MSB is at bit IN_W-1 (lzc = 0).
    localparam int EBASE = IN_W - 1 - FRAC_BITS + 15;

    // Index of the highest set bit, expressed as a count of leading zeros.
    // Scanning upward lets the highest set bit win. A zero word yields IN_W.
    function automatic logic [LZW-1:0] lzc_f(input logic [IN_W-1:0] v);
        logic [LZW-1:0] cnt;
        cnt = LZW'(IN_W);
        for (int i = 0; i < IN_W; i++) begin
            cnt = v[i] ? LZW'(IN_W - 1 - i) : cnt;
        end
        return cnt;
    endfunction

    // ---------------------------------------------------------------------
    // Handshake
    // ---------------------------------------------------------------------
    logic adv_s;
    logic out_valid_q;
    logic [15:0] out_data_q;

    assign adv_s     = ~out_valid_q | out_ready;
    assign in_ready  = adv_s;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // ---------------------------------------------------------------------
    // Stage 1: sign and magnitude
    // ---------------------------------------------------------------------
    logic            s1_valid_q;
    logic            s1_sign_q;
    logic [IN_W-1:0] s1_mag_q;
    logic            s1_sign_d;
    logic [IN_W-1:0] s1_mag_d;

    // Absolute value. The most negative input maps onto 2^(IN_W-1), which
    // still fits as an unsigned IN_W-bit magnitude.
    always_comb begin
        s1_sign_d = in_data[IN_W-1];
        if (s1_sign_d) begin
            s1_mag_d = ~in_data + IN_W'(1);
        end else begin
            s1_mag_d = in_data;
        end
    end

    // Stage-1 register. Payload is captured only on an input transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_mag_q   <= '0;
        end else if (adv_s) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_sign_q <= s1_sign_d;
                s1_mag_q  <= s1_mag_d;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stage 2: normalise
    // ---------------------------------------------------------------------
    logic                   s2_valid_q;
    logic                   s2_sign_q;
    logic                   s2_zero_q;
    logic [IN_W-1:0]        s2_norm_q;
    logic signed [7:0]      s2_bexp_q;
    logic [LZW-1:0]         lzc_s;
    logic [IN_W-1:0]        s2_norm_d;
    logic signed [7:0]      s2_bexp_d;
    logic                   s2_zero_d;

    // Move the leading one to the top bit. The biased exponent is
    // (IN_W-1-lzc) - FRAC_BITS + 15. It can go negative for deep
    // subnormals, hence the signed 8-bit carrier.
    always_comb begin
        lzc_s     = lzc_f(s1_mag_q);
        s2_norm_d = s1_mag_q << lzc_s;
        s2_bexp_d = 8'(EBASE) - 8'(lzc_s);
        s2_zero_d = (s1_mag_q == '0);
    end

    // Stage-2 register. Payload moves only with a valid stage-1 word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_zero_q  <= 1'b0;
            s2_norm_q  <= '0;
            s2_bexp_q  <= 8'sd0;
        end else if (adv_s) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_sign_q <= s1_sign_q;
                s2_zero_q <= s2_zero_d;
                s2_norm_q <= s2_norm_d;
                s2_bexp_q <= s2_bexp_d;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stage 3: round and pack
    // ---------------------------------------------------------------------
    logic              normal_s;
    logic signed [7:0] den_s;
    logic [5:0]        sh_s;
    logic [WW-1:0]     work_s;
    logic [10:0]       mant_s;
    logic              guard_s;
    logic              sticky_s;
    logic              rnd_up_s;
    logic [11:0]       mant_r_s;
    logic signed [7:0] exp_fin_s;
    logic [14:0]       sub_mag_s;
    logic [15:0]       res_s;
`ifdef FP16_INEXACT_EN
    logic              inx_s;
    logic              out_inexact_q;
    assign out_inexact = out_inexact_q;
`endif

    // Subnormals reuse the normal rounding path. The significand is first
    // shifted right so that its bit 10 carries weight 2^-14. The same
    // 11-bit/guard/sticky split then yields the subnormal fraction. A round
    // carry into bit 10 naturally becomes exponent field 1 with fraction 0.
    always_comb begin
        normal_s  = (s2_bexp_q > 8'sd0);
        den_s     = 8'sd1 - s2_bexp_q;
        if (normal_s) begin
            sh_s = 6'd0;
        end else if (den_s > 8'sd31) begin
            sh_s = 6'd31;
        end else begin
            sh_s = den_s[5:0];
        end
        work_s    = {s2_norm_q, {PAD{1'b0}}} >> sh_s;
        mant_s    = work_s[WW-1 -: 11];
        guard_s   = work_s[WW-12];
        sticky_s  = |work_s[WW-13:0];
        rnd_up_s  = guard_s & (sticky_s | mant_s[0]);
        mant_r_s  = {1'b0, mant_s} + {11'd0, rnd_up_s};
        exp_fin_s = s2_bexp_q + $signed({7'd0, mant_r_s[11]});
        sub_mag_s = {4'd0, mant_r_s[10:0]};
        res_s     = 16'h0000;
`ifdef FP16_INEXACT_EN
        inx_s     = 1'b0;
`endif
        if (s2_zero_q) begin
            res_s = 16'h0000;
        end else if (normal_s) begin
            if (exp_fin_s >= 8'sd31) begin
                res_s = {s2_sign_q, 5'h1F, 10'h000};
`ifdef FP16_INEXACT_EN
                inx_s = 1'b1;
`endif
            end else begin
                // On a mantissa carry, mant_r_s[9:0] is already zero.
                res_s = {s2_sign_q, exp_fin_s[4:0], mant_r_s[9:0]};
`ifdef FP16_INEXACT_EN
                inx_s = guard_s | sticky_s;
`endif
            end
        end else begin
            // A tiny value that rounds to zero is emitted as +0, never -0.
            res_s = {s2_sign_q & (sub_mag_s != 15'd0), sub_mag_s};
`ifdef FP16_INEXACT_EN
            inx_s = guard_s | sticky_s;
`endif
        end
    end

    // Output register. out_data holds while the downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_data_q    <= 16'h0000;
`ifdef FP16_INEXACT_EN
            out_inexact_q <= 1'b0;
`endif
        end else if (adv_s) begin
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                out_data_q    <= res_s;
`ifdef FP16_INEXACT_EN
                out_inexact_q <= inx_s;
`endif
            end
        end
    end

endmodule

// File: tb/tb_fixed_to_fp16.sv
// -----------------------------------------------------------------------------
// tb_fixed_to_fp16
//   Self-checking bench for fixed_to_fp16. Three instances are used:
//     dut_a  IN_W=16, FRAC_BITS=8
//     dut_b  IN_W=32, FRAC_BITS=0   (top of the FP16 range, overflow to inf)
//     dut_c  IN_W=32, FRAC_BITS=25  (bottom of the subnormal range, ties at 2^-25)
//   Expected values come from fixed constants or from ref_fp16. ref_fp16
//   rounds value/quantum with integer remainder arithmetic.
// -----------------------------------------------------------------------------
module tb_fixed_to_fp16;

`ifdef FP16_INEXACT_EN
    localparam bit INX_EN = 1'b1;
`else
    localparam bit INX_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [15:0] a_in_data, a_out_data;
    logic        a_inx;

    logic        w_in_valid, w_out_ready;
    logic        b_in_ready, b_out_valid, c_in_ready, c_out_valid;
    logic [31:0] b_in_data, c_in_data;
    logic [15:0] b_out_data, c_out_data;
    logic        b_inx, c_inx;

    fixed_to_fp16 #(.IN_W(16), .FRAC_BITS(8)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data)
`ifdef FP16_INEXACT_EN
        , .out_inexact(a_inx)
`endif
    );

    fixed_to_fp16 #(.IN_W(32), .FRAC_BITS(0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(w_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(w_out_ready), .out_data(b_out_data)
`ifdef FP16_INEXACT_EN
        , .out_inexact(b_inx)
`endif
    );

    fixed_to_fp16 #(.IN_W(32), .FRAC_BITS(25)) dut_c (
        .clk(clk), .rst_n(rst_n),
        .in_valid(w_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(w_out_ready), .out_data(c_out_data)
`ifdef FP16_INEXACT_EN
        , .out_inexact(c_inx)
`endif
    );

`ifndef FP16_INEXACT_EN
    assign a_inx = 1'b0;
    assign b_inx = 1'b0;
    assign c_inx = 1'b0;
`endif

    // Reference: returns {inexact, fp16} for value v / 2^frac.
    function automatic logic [16:0] ref_fp16(input longint v, input int frac);
        longint m, n, r, half;
        int     msb, e, k;
        logic   s, inx;
        s = (v < 0);
        m = s ? -v : v;
        if (m == 0) return 17'h00000;
        msb = 0;
        for (int i = 0; i < 62; i++) if (((m >> i) & 64'sd1) != 0) msb = i;
        e = msb - frac;                 // floor(log2(value))
        if (e < -14) e = -14;           // subnormal range shares the 2^-24 quantum
        k = 10 - frac - e;              // n = value / 2^(e-10)
        r = 0;
        half = 0;
        if (k >= 0) begin
            n = m << k;
        end else begin
            n = m >> (-k);
            r = m - (n << (-k));
            half = longint'(1) << (-k - 1);
            if (r > half || (r == half && n[0])) n = n + 1;
        end
        inx = (r != 0);
        if (n == 2048) begin
            n = 1024;
            e = e + 1;
        end
        if (e > 15) return {1'b1, s, 5'h1F, 10'h000};
        if (n == 0) return {inx, 16'h0000};
        if (n < 1024) return {inx, s, 5'd0, n[9:0]};
        return {inx, s, 5'(e + 15), n[9:0]};
    endfunction

    function automatic logic [16:0] mask_inx(input logic [16:0] x);
        return {x[16] & INX_EN, x[15:0]};
    endfunction

    function automatic logic [15:0] rand16();
        logic [15:0] x;
        case ($urandom_range(3))
            0:       x = 16'($urandom);
            1:       x = 16'($urandom_range(255));
            2:       x = 16'h8000 + 16'($urandom_range(15)) - 16'd8;
            default: x = 16'(-$urandom_range(4095));
        endcase
        return x;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (a_out_valid !== 1'b0 || a_out_data !== 16'h0000 || a_inx !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: valid=%b data=%h inx=%b, need 0/0000/0", a_out_valid, a_out_data, a_inx);
        end
        checks++;
        if (a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b need 1", a_in_ready);
        end
        checks++;
        if (b_out_valid !== 1'b0 || c_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_wide: b=%b c=%b need 0", b_out_valid, c_out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drives one word into dut_a and checks the 3-cycle latency and the result.
    task automatic single_a(input logic [15:0] din, input logic [16:0] expv, input string name);
        @(negedge clk);
        a_in_valid  = 1'b1;
        a_in_data   = din;
        a_out_ready = 1'b1;
        @(posedge clk);
        #1 a_in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (a_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_latency_early: out_valid=%b after 2 cycles, need 0", name, a_out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (a_out_valid !== 1'b1 || {a_inx, a_out_data} !== mask_inx(expv)) begin
            errors++;
            $display("FAIL %s: valid=%b inx/data=%h need 1 and %h", name, a_out_valid, {a_inx, a_out_data}, mask_inx(expv));
        end
    endtask

    task automatic test_directed();
        logic [15:0] din [8];
        logic [16:0] dexp[8];
        din[0] = 16'h0100; dexp[0] = {1'b0, 16'h3C00};
        din[1] = 16'hFF00; dexp[1] = {1'b0, 16'hBC00};
        din[2] = 16'h0000; dexp[2] = {1'b0, 16'h0000};
        din[3] = 16'h8000; dexp[3] = {1'b0, 16'hD800};
        din[4] = 16'h0001; dexp[4] = {1'b0, 16'h1C00};
        din[5] = 16'h7FFF; dexp[5] = {1'b1, 16'h5800};
        din[6] = 16'h0801; dexp[6] = {1'b1, 16'h4800};
        din[7] = 16'h0803; dexp[7] = {1'b1, 16'h4802};
        for (int i = 0; i < 8; i++) single_a(din[i], dexp[i], $sformatf("directed%0d", i));
    endtask

    task automatic test_wide();
        logic [16:0] qb[$];
        logic [16:0] qc[$];
        logic [31:0] vb, vc;
        logic [16:0] e;
        int n = 43;
        for (int cyc = 0; cyc < n + 8; cyc++) begin
            @(negedge clk);
            w_out_ready = 1'b1;
            w_in_valid  = (cyc < n);
            case (cyc)
                0: begin vb = 32'd65519;  vc = 32'd1; end
                1: begin vb = 32'd65520;  vc = 32'd2; end
                2: begin vb = -32'sd65520; vc = 32'd3; end
                default: begin
                    vb = ($urandom_range(1) == 0) ? $urandom : 32'($urandom_range(70000)) - 32'd35000;
                    vc = ($urandom_range(1) == 0) ? 32'($urandom_range(5000)) : $urandom;
                end
            endcase
            b_in_data = vb;
            c_in_data = vc;
            #1;
            if (b_out_valid) begin
                checks++;
                e = (qb.size() > 0) ? qb.pop_front() : 17'h1FFFF;
                if ({b_inx, b_out_data} !== mask_inx(e)) begin
                    errors++;
                    $display("FAIL wide_b: got %h need %h", {b_inx, b_out_data}, mask_inx(e));
                end
            end
            if (c_out_valid) begin
                checks++;
                e = (qc.size() > 0) ? qc.pop_front() : 17'h1FFFF;
                if ({c_inx, c_out_data} !== mask_inx(e)) begin
                    errors++;
                    $display("FAIL wide_c: got %h need %h", {c_inx, c_out_data}, mask_inx(e));
                end
            end
            if (w_in_valid && b_in_ready && c_in_ready) begin
                case (cyc)
                    0: begin qb.push_back({1'b1, 16'h7BFF}); qc.push_back({1'b1, 16'h0000}); end
                    1: begin qb.push_back({1'b1, 16'h7C00}); qc.push_back({1'b0, 16'h0001}); end
                    2: begin qb.push_back({1'b1, 16'hFC00}); qc.push_back({1'b1, 16'h0002}); end
                    default: begin
                        qb.push_back(ref_fp16(longint'($signed(vb)), 0));
                        qc.push_back(ref_fp16(longint'($signed(vc)), 25));
                    end
                endcase
            end
        end
        w_in_valid = 1'b0;
        checks++;
        if (qb.size() != 0 || qc.size() != 0) begin
            errors++;
            $display("FAIL wide_drain: %0d/%0d words missing, need 0/0", qb.size(), qc.size());
        end
    endtask

    task automatic test_back_to_back(input int nwords, input int vpct, input int rpct, input string name);
        logic [16:0] q[$];
        logic [16:0] e;
        logic        prev_stall = 1'b0;
        logic [16:0] prev_obs = '0;
        int          sent = 0;
        int          cycles = 0;
        while ((sent < nwords || q.size() > 0) && cycles < 4000) begin
            @(negedge clk);
            a_in_valid  = (sent < nwords) && ($urandom_range(99) < vpct);
            a_in_data   = rand16();
            a_out_ready = ($urandom_range(99) < rpct);
            #1;
            checks++;
            if (a_in_ready !== (~a_out_valid | a_out_ready)) begin
                errors++;
                $display("FAIL %s_in_ready: got %b need %b", name, a_in_ready, ~a_out_valid | a_out_ready);
            end
            if (prev_stall) begin
                checks++;
                if (a_out_valid !== 1'b1 || {a_inx, a_out_data} !== prev_obs) begin
                    errors++;
                    $display("FAIL %s_stall_hold: valid=%b data=%h need 1 and %h", name, a_out_valid, {a_inx, a_out_data}, prev_obs);
                end
            end
            if (a_out_valid && a_out_ready) begin
                checks++;
                e = (q.size() > 0) ? mask_inx(q.pop_front()) : 17'h1FFFF;
                if ({a_inx, a_out_data} !== e) begin
                    errors++;
                    $display("FAIL %s_data: got %h need %h", name, {a_inx, a_out_data}, e);
                end
            end
            if (a_in_valid && a_in_ready) begin
                q.push_back(ref_fp16(longint'($signed(a_in_data)), 8));
                sent++;
            end
            prev_stall = a_out_valid & ~a_out_ready;
            prev_obs   = {a_inx, a_out_data};
            cycles++;
        end
        checks++;
        if (cycles >= 4000) begin
            errors++;
            $display("FAIL %s_timeout: sent %0d pending %0d, need all delivered", name, sent, q.size());
        end
        @(negedge clk);
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_inflight();
        @(negedge clk);
        a_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = 16'h0100 + 16'(i);
            @(negedge clk);
        end
        a_in_valid = 1'b0;
        #1;
        checks++;
        if (a_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL inflight_fill: out_valid=%b need 1", a_out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (a_out_valid !== 1'b0 || a_out_data !== 16'h0000) begin
            errors++;
            $display("FAIL inflight_async: valid=%b data=%h need 0/0000", a_out_valid, a_out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        a_out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (a_out_valid !== 1'b0) begin
                errors++;
                $display("FAIL inflight_stale%0d: out_valid=%b need 0", i, a_out_valid);
            end
        end
        single_a(16'hFE80, {1'b0, 16'hBE00}, "after_reset");
    endtask

    initial begin
        rst_n       = 1'b0;
        a_in_valid  = 1'b0;
        a_in_data   = 16'h0000;
        a_out_ready = 1'b0;
        w_in_valid  = 1'b0;
        w_out_ready = 1'b1;
        b_in_data   = 32'h0;
        c_in_data   = 32'h0;
        test_reset();
        test_directed();
        test_wide();
        test_back_to_back(8, 100, 50, "b2b");
        test_back_to_back(300, 70, 60, "random");
        test_reset_inflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
